pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Merges three stall/flush sources into one set of stage-register write-enables, bubble and flush controls:
  - load-use hazard, from the hazard detection unit;
  - control-flow redirect (taken branch or jump resolved in ID);
  - multi-cycle data-memory handshake.
- Owns the run/idle/memory-wait FSM and a memory watchdog. Sits beside the hazard unit; drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- TIMEOUT, 64: max MEM_WAIT cycles before watchdog error; legal range 2..255.
- CNT_W, 32: width of performance counters (optional feature only).

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  level; leave IDLE and begin fetching
- ld_hazard_i  in  1  load-use hazard request from hazard detection unit
- redirect_i  in  1  taken branch/jump resolved in ID this cycle
- mem_acc_i  in  1  instruction in MEM stage is a load or store
- mem_ack_i  in  1  data memory completes access this cycle
- mem_req_o  out  1  data memory request
- pc_we_o  out  1  PC write enable
- if_id_we_o  out  1  IF/ID write enable
- if_id_flush_o  out  1  load NOP into IF/ID
- id_ex_bubble_o  out  1  zero control bits into ID/EX
- stage_we_o  out  1  ID/EX, EX/MEM, MEM/WB write enable
- err_o  out  1  sticky watchdog error
- lu_cnt_o  out  CNT_W  load-use stall cycles (optional feature)
- mw_cnt_o  out  CNT_W  memory-wait cycles (optional feature)

Behaviour:
- FSM states: IDLE, RUN, MEM_WAIT, HALT. Reset (rst_i=0) forces IDLE asynchronously, clears err_o and the watchdog counter.
- Control outputs are combinational (Mealy) from state and inputs. Reset/IDLE values: mem_req_o=0, pc_we_o=0, if_id_we_o=0, if_id_flush_o=0, id_ex_bubble_o=0, stage_we_o=0, err_o=0.
- IDLE:
  - all enables 0;
  - start_i=1 -> RUN next edge.
- RUN, evaluated in priority order:
  - mem_acc_i=1 and mem_ack_i=0:
    - mem_req_o=1;
    - all enables 0, flush=0, bubble=0 (full freeze);
    - -> MEM_WAIT; watchdog loads 1.
    - Freeze dominates ld_hazard_i and redirect_i; those inputs re-evaluate when the pipeline resumes.
  - ld_hazard_i=1:
    - pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1, stage_we_o=1;
    - redirect_i ignored this cycle (branch re-resolves next cycle with correct operands);
    - mem_req_o=mem_acc_i.
  - redirect_i=1:
    - pc_we_o=1, if_id_we_o=1, if_id_flush_o=1, stage_we_o=1;
    - mem_req_o=mem_acc_i.
  - else:
    - pc_we_o=1, if_id_we_o=1, stage_we_o=1;
    - mem_req_o=mem_acc_i.
  - Zero-wait memory (mem_acc_i=1 and mem_ack_i=1 in RUN): no stall; handled as if no access was pending.
- MEM_WAIT:
  - mem_req_o held 1 continuously until acknowledged;
  - all enables 0;
  - watchdog increments each cycle.
  - mem_ack_i=1: this cycle behaves exactly as RUN with the access completed (enables per ld_hazard_i/redirect_i priority); -> RUN.
  - watchdog reaching TIMEOUT without ack: err_o=1 (sticky) -> HALT.
- HALT:
  - all outputs 0 except err_o=1;
  - only reset exits.
- Watchdog is 8-bit saturating and clears on every RUN entry.
- start_i is only sampled in IDLE; deasserting it later has no effect.
- mem_ack_i outside a request cycle is ignored.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - lu_cnt_o increments on every RUN cycle where ld_hazard_i causes a bubble;
  - mw_cnt_o increments on every MEM_WAIT cycle;
  - both CNT_W-bit, wrap modulo 2^CNT_W, cleared by reset.
- Undefined: both outputs constant 0 and no counter flops are synthesized.

Test Plan:
- Reset then start_i=1 for 1 cycle, no hazards -> IDLE outputs all 0; from 2nd edge pc_we_o=if_id_we_o=stage_we_o=1, err_o=0.
- RUN, ld_hazard_i=1 and redirect_i=1 same cycle -> pc_we_o=0, if_id_we_o=0, id_ex_bubble_o=1, if_id_flush_o=0; next cycle redirect_i alone -> if_id_flush_o=1. With macro defined, lu_cnt_o=1.
- mem_acc_i=1, mem_ack_i delayed 3 cycles -> mem_req_o=1 for 4 consecutive cycles, stage_we_o=0 for the first 3, 1 on the ack cycle. With macro defined, mw_cnt_o=3.
- mem_acc_i=1 with mem_ack_i=1 same cycle -> no freeze, stays RUN, stage_we_o=1.
- TIMEOUT=4, mem_ack_i never asserted -> err_o=1 after 4 MEM_WAIT cycles; outputs 0 thereafter; pulse rst_i=0 mid-HALT -> err_o=0, state IDLE immediately (asynchronous).
- rst_i asserted mid-MEM_WAIT -> mem_req_o drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges load-use, redirect and data-memory stalls into stage controls.
// Optional performance counters are enabled by defining STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             ld_hazard_i,
    input  logic             redirect_i,
    input  logic             mem_acc_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             stage_we_o,
    output logic             err_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] mw_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       issue;

    always_comb begin
        state_d        = state_q;
        wdog_d         = wdog_q;
        err_d          = err_q;
        issue          = 1'b0;
        mem_req_o      = 1'b0;
        pc_we_o        = 1'b0;
        if_id_we_o     = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        stage_we_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    wdog_d  = 8'd0;
                end
            end
            S_RUN: begin
                // An outstanding access freezes everything, including hazard/redirect handling.
                if (mem_acc_i && !mem_ack_i) begin
                    mem_req_o = 1'b1;
                    state_d   = S_MW;
                    wdog_d    = 8'd1;
                end else begin
                    mem_req_o = mem_acc_i;
                    issue     = 1'b1;
                end
            end
            S_MW: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    issue   = 1'b1;
                    state_d = S_RUN;
                    wdog_d  = 8'd0;
                end else if (wdog_q >= WD_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (wdog_q != 8'hFF) begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Load-use wins over redirect: the branch re-resolves once operands are forwarded.
        if (issue) begin
            if (ld_hazard_i) begin
                id_ex_bubble_o = 1'b1;
                stage_we_o     = 1'b1;
            end else if (redirect_i) begin
                pc_we_o       = 1'b1;
                if_id_we_o    = 1'b1;
                if_id_flush_o = 1'b1;
                stage_we_o    = 1'b1;
            end else begin
                pc_we_o    = 1'b1;
                if_id_we_o = 1'b1;
                stage_we_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wdog_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, mw_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
        end else begin
            if (id_ex_bubble_o) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (state_q == S_MW) mw_cnt_q <= mw_cnt_q + CNT_W'(1);
        end
    end

    assign lu_cnt_o = lu_cnt_q;
    assign mw_cnt_o = mw_cnt_q;
`else
    assign lu_cnt_o = '0;
    assign mw_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl, built with TIMEOUT=4 so the watchdog path is short.
module tb_pipe_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, ld_hazard_i, redirect_i, mem_acc_i, mem_ack_i;
    logic        mem_req_o, pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o, stage_we_o, err_o;
    logic [31:0] lu_cnt_o, mw_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stall_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .ld_hazard_i(ld_hazard_i), .redirect_i(redirect_i),
        .mem_acc_i(mem_acc_i), .mem_ack_i(mem_ack_i),
        .mem_req_o(mem_req_o), .pc_we_o(pc_we_o), .if_id_we_o(if_id_we_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_bubble_o(id_ex_bubble_o),
        .stage_we_o(stage_we_o), .err_o(err_o),
        .lu_cnt_o(lu_cnt_o), .mw_cnt_o(mw_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {mem_req, pc_we, if_id_we, flush, bubble, stage_we, err}.
    function automatic logic [31:0] outs();
        return {25'd0, mem_req_o, pc_we_o, if_id_we_o, if_id_flush_o, id_ex_bubble_o, stage_we_o, err_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; ld_hazard_i = 1'b0; redirect_i = 1'b0;
        mem_acc_i = 1'b0; mem_ack_i = 1'b0;
        #2;
        chk("reset_outs", outs(), 32'b0000000);
        chk("reset_lu", lu_cnt_o, 32'd0);
        chk("reset_mw", mw_cnt_o, 32'd0);
        #1 rst_i = 1'b1;

        // IDLE: start seen but enables stay low until the next edge
        tick();
        chk("idle_outs", outs(), 32'b0000000);
        start_i = 1'b1; #1;
        chk("idle_start_outs", outs(), 32'b0000000);
        tick();
        start_i = 1'b0; #1;
        chk("run_plain", outs(), 32'b0110010);

        // load-use and redirect together, then redirect alone
        ld_hazard_i = 1'b1; redirect_i = 1'b1; #1;
        chk("lu_over_redirect", outs(), 32'b0000110);
        tick();
        ld_hazard_i = 1'b0; #1;
        chk("redirect_flush", outs(), 32'b0111010);
`ifdef STALL_PERF_CNT_EN
        chk("lu_cnt_1", lu_cnt_o, 32'd1);
`else
        chk("lu_cnt_off", lu_cnt_o, 32'd0);
`endif
        tick();
        redirect_i = 1'b0;

        // memory access acked on the 4th request cycle; freeze beats ld_hazard
        mem_acc_i = 1'b1; ld_hazard_i = 1'b1; #1;
        chk("mw_freeze", outs(), 32'b1000000);
        tick();
        ld_hazard_i = 1'b0; #1;
        chk("mw_wait1", outs(), 32'b1000000);
        tick();
        chk("mw_wait2", outs(), 32'b1000000);
        tick();
        mem_ack_i = 1'b1; #1;
        chk("mw_ack", outs(), 32'b1110010);
        tick();
        mem_acc_i = 1'b0; mem_ack_i = 1'b0; #1;
        chk("mw_back_run", outs(), 32'b0110010);
`ifdef STALL_PERF_CNT_EN
        chk("mw_cnt_3", mw_cnt_o, 32'd3);
`else
        chk("mw_cnt_off", mw_cnt_o, 32'd0);
`endif

        // zero-wait access stays in RUN
        mem_acc_i = 1'b1; mem_ack_i = 1'b1; #1;
        chk("zero_wait", outs(), 32'b1110010);
        tick();
        mem_acc_i = 1'b0; #1;
        chk("zero_wait_stay_run", outs(), 32'b0110010);
        tick();
        mem_ack_i = 1'b0;

        // ack cycle in MEM_WAIT honours load-use priority
        mem_acc_i = 1'b1; #1;
        tick();
        mem_ack_i = 1'b1; ld_hazard_i = 1'b1; #1;
        chk("mw_ack_lu", outs(), 32'b1000110);
        tick();
        mem_acc_i = 1'b0; mem_ack_i = 1'b0; ld_hazard_i = 1'b0;

        // watchdog: no ack for TIMEOUT MEM_WAIT cycles
        mem_acc_i = 1'b1; #1;
        chk("wd_freeze", outs(), 32'b1000000);
        tick(); tick(); tick(); tick();
        chk("wd_wait4", outs(), 32'b1000000);
        tick();
        start_i = 1'b1; #1;
        chk("halt_outs", outs(), 32'b0000001);
        tick();
        chk("halt_sticky", outs(), 32'b0000001);

        // asynchronous reset in HALT
        start_i = 1'b0; mem_acc_i = 1'b0;
        rst_i = 1'b0; #1;
        chk("halt_async_rst", outs(), 32'b0000000);
        rst_i = 1'b1;
        tick();
        chk("idle_after_rst", outs(), 32'b0000000);

        // asynchronous reset in MEM_WAIT drops the request immediately
        start_i = 1'b1;
        tick();
        start_i = 1'b0; mem_acc_i = 1'b1;
        tick();
        chk("mw_before_rst", outs(), 32'b1000000);
        rst_i = 1'b0; #1;
        chk("mw_async_rst", outs(), 32'b0000000);
        rst_i = 1'b1; mem_acc_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
